// File: rtl/arb_mux.sv
// arb_mux: N-to-1 round-robin arbitrating mux feeding one registered valid/ready output stage.
// Define ARB_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module arb_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 3,
  localparam int IDX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_arst_n,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_INPUTS-1:0]            o_ready,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [IDX_WIDTH-1:0]             o_sel,
  input  logic                             i_ready
);
  logic [NUM_INPUTS-1:0] grant;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  found;
  logic                  can_load;
  logic                  accept;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [IDX_WIDTH-1:0]  o_sel_q, o_sel_d;
  int                    k;
`ifndef ARB_MUX_FIXED_PRIO_EN
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
`endif
  // Scan candidates in priority order (from ptr, or from 0 in fixed mode); first valid one wins.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    grant_data = '0;
    found = 1'b0;
    k = 0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
      k = j;
`else
      k = int'(ptr_q) + j;
      k = (k >= NUM_INPUTS) ? k - NUM_INPUTS : k;
`endif
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!found && i == k && i_valid[i]) begin
          found = 1'b1;
          grant[i] = 1'b1;
          grant_idx = IDX_WIDTH'(i);
          grant_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end
  // Stage can refill whenever it is empty or draining this cycle; ready is forced low in reset.
  always_comb begin
    can_load = ~o_valid_q | i_ready;
    accept = found & can_load;
    o_ready = (i_arst_n && can_load) ? grant : '0;
  end
  // Next-state for the output register: load on accept, drop valid on drain, otherwise hold.
  always_comb begin
    o_valid_d = accept | (o_valid_q & ~i_ready);
    o_data_d = accept ? grant_data : o_data_q;
    o_sel_d = accept ? grant_idx : o_sel_q;
  end
`ifndef ARB_MUX_FIXED_PRIO_EN
  // Pointer moves just past the winner on accept, with explicit wrap at NUM_INPUTS-1.
  always_comb begin
    ptr_d = accept ? ((grant_idx == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1) : ptr_q;
  end
  // Round-robin pointer register; idle cycles leave it untouched.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif
  // Output stage register; reset discards any held transfer immediately.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_sel_q <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      o_sel_q <= o_sel_d;
    end
  end
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_sel = o_sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed scoreboard bench for arb_mux (3 inputs, 64-bit payloads).
module tb_arb_mux;
  localparam int DW = 64;
  localparam int N = 3;
  localparam int IW = 2;
  logic              i_clk = 1'b0;
  logic              i_arst_n = 1'b0;
  logic [N-1:0]      i_valid = '0;
  logic [N*DW-1:0]   i_data;
  logic [N-1:0]      o_ready;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic [IW-1:0]     o_sel;
  logic              i_ready = 1'b0;
  logic [DW-1:0]     din [N];
  logic [IW+DW-1:0]  sb [$];
  logic [IW+DW-1:0]  exp_item;
  int                checks = 0;
  int                fails = 0;
  arb_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_sel(o_sel), .i_ready(i_ready)
  );
  assign i_data = {din[2], din[1], din[0]};
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Monitor: every downstream transfer must match the oldest expected item.
  always @(negedge i_clk) begin
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL xfer_unexpected: got sel %0d data %0h, expected no transfer", o_sel, o_data);
      end else begin
        exp_item = sb.pop_front();
        chk("xfer_sel", DW'(o_sel), DW'(exp_item[IW+DW-1:DW]));
        chk("xfer_data", o_data, exp_item[DW-1:0]);
      end
    end
  end
  // One cycle of stimulus: drive, check the combinational grant, queue the expected transfer.
  task automatic step(input logic [N-1:0] v, input logic r, input logic acc, input int sel);
    logic [N-1:0] er;
    i_valid = v;
    i_ready = r;
    er = acc ? (N'(1) << sel) : '0;
    if (acc) sb.push_back({IW'(sel), din[sel]});
    #1;
    chk("o_ready", DW'(o_ready), DW'(er));
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    din[0] = 64'hA0;
    din[1] = 64'hB1;
    din[2] = 64'hC2;
    i_valid = '1;
    i_ready = 1'b1;
    #3;
    chk("rst_valid", DW'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_sel", DW'(o_sel), 0);
    chk("rst_ready", DW'(o_ready), 0);
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
`ifdef ARB_MUX_FIXED_PRIO_EN
    repeat (10) step(3'b101, 1'b1, 1'b1, 0);
`else
    for (int c = 0; c < 6; c++) step('1, 1'b1, 1'b1, c % 3);
    step('1, 1'b1, 1'b1, 0);
    step('1, 1'b1, 1'b1, 1);
    repeat (4) begin
      i_valid = '1;
      i_ready = 1'b0;
      #1;
      chk("stall_ready", DW'(o_ready), 0);
      chk("stall_data", o_data, 64'hB1);
      chk("stall_sel", DW'(o_sel), 1);
      @(posedge i_clk);
      #1;
    end
    step('1, 1'b1, 1'b1, 2);
    step(3'b100, 1'b1, 1'b1, 2);
    step(3'b101, 1'b1, 1'b1, 0);
    step(3'b101, 1'b1, 1'b1, 2);
    din[1] = 64'h55;
    step(3'b010, 1'b1, 1'b1, 1);
    din[1] = 64'hB1;
    chk("drain_full", DW'(o_valid), 1);
    step('0, 1'b1, 1'b0, 0);
    chk("drain_empty", DW'(o_valid), 0);
    chk("drain_data", o_data, 64'h55);
    chk("drain_sel", DW'(o_sel), 1);
    i_valid = 3'b010;
    i_ready = 1'b0;
    #1;
    chk("pre_rst_ready", DW'(o_ready), 3'b010);
    @(posedge i_clk);
    #1;
    i_valid = '0;
    chk("pre_rst_valid", DW'(o_valid), 1);
    chk("pre_rst_sel", DW'(o_sel), 1);
    i_arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(o_valid), 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_sel", DW'(o_sel), 0);
    i_valid = '1;
    #1;
    chk("mid_rst_ready", DW'(o_ready), 0);
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    step('1, 1'b1, 1'b1, 0);
`endif
    step('0, 1'b1, 1'b0, 0);
    step('0, 1'b1, 1'b0, 0);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending transfers, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
